// File: rtl/dot_acc_pipe_pkg.sv
// Shared defaults, beat flag bundle and elaboration-time helpers for the
// dot-product accumulate pipeline.
package dot_acc_pipe_pkg;

    localparam int DATA_LEN_DEF = 16;
    localparam int DATA_DEC_DEF = 8;
    localparam int TAPS_DEF     = 9;
    localparam int ACC_LEN_DEF  = 32;

    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } beat_flags_t;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Number of elements left after lvl pairwise-add levels starting from n.
    function automatic int tree_count(input int n, input int lvl);
        int c;
        c = n;
        for (int k = 0; k < lvl; k++) begin
            c = (c + 1) / 2;
        end
        return c;
    endfunction

endpackage

// File: rtl/dot_acc_pipe_add_tree_stage.sv
// One registered pairwise-add level of the reduction tree; an odd trailing
// element is forwarded unchanged. Beat flags ride along with the data.
module add_tree_stage
    import dot_acc_pipe_pkg::*;
#(
    parameter int N = 2,
    parameter int W = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  beat_flags_t              in_flags,
    input  logic [N*W-1:0]           din,
    output beat_flags_t              out_flags,
    output logic [((N+1)/2)*W-1:0]   dout
);

    localparam int M = (N + 1) / 2;

    logic [M*W-1:0] sum_s;

    for (genvar j = 0; j < M; j++) begin : gen_pair
        if (2 * j + 1 < N) begin : g_add
            assign sum_s[j*W +: W] = din[2*j*W +: W] + din[(2*j+1)*W +: W];
        end else begin : g_pass
            assign sum_s[j*W +: W] = din[2*j*W +: W];
        end
    end

    // Level register: flags always advance, data only on valid beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_flags <= 3'b000;
            dout      <= {(M*W){1'b0}};
        end else if (clr) begin
            out_flags <= 3'b000;
        end else begin
            out_flags <= in_flags;
            if (in_flags.valid) begin
                dout <= sum_s;
            end
        end
    end

endmodule

// File: rtl/dot_acc_pipe.sv
// Signed fixed-point dot-product engine: per-beat multiply, registered adder
// tree, cross-beat accumulation, bias, optional ReLU and saturate/wrap.
module dot_acc_pipe
    import dot_acc_pipe_pkg::*;
#(
    parameter int DATA_LEN = DATA_LEN_DEF,
    parameter int DATA_DEC = DATA_DEC_DEF,
    parameter int TAPS     = TAPS_DEF,
    parameter int ACC_LEN  = ACC_LEN_DEF,
    parameter int SAT      = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     in_valid,
    input  logic                     in_first,
    input  logic                     in_last,
    input  logic [TAPS*DATA_LEN-1:0] d1,
    input  logic [TAPS*DATA_LEN-1:0] d2,
    input  logic [DATA_LEN-1:0]      bias,
    input  logic                     relu_en,
    output logic                     out_valid,
    output logic [DATA_LEN-1:0]      q
);

    localparam int LEAVES = TAPS + 1;
    localparam int DEPTH  = clog2(LEAVES);

    logic [LEAVES*ACC_LEN-1:0] leaf_s;
    logic [LEAVES*ACC_LEN-1:0] leaf_r;
    beat_flags_t               m_flags_r;
    logic [ACC_LEN-1:0]        tree_s;
    beat_flags_t               t_flags_s;
    logic [ACC_LEN-1:0]        acc_r;
    logic [ACC_LEN-1:0]        acc_next_s;

    // ReLU, then clamp to the signed DATA_LEN range or keep the low bits.
    function automatic logic [DATA_LEN-1:0] fmt(input logic [ACC_LEN-1:0] v,
                                                input logic relu);
        logic [ACC_LEN-1:0]          r;
        logic [ACC_LEN-DATA_LEN:0]   hi;
        r  = (relu && v[ACC_LEN-1]) ? {ACC_LEN{1'b0}} : v;
        hi = r[ACC_LEN-1:DATA_LEN-1];
        if (SAT == 0 || (&hi) || !(|hi)) begin
            return r[DATA_LEN-1:0];
        end else if (r[ACC_LEN-1]) begin
            return {1'b1, {(DATA_LEN-1){1'b0}}};
        end else begin
            return {1'b0, {(DATA_LEN-1){1'b1}}};
        end
    endfunction

    // Floor-scaled products sign-extended to the accumulator width.
    for (genvar i = 0; i < TAPS; i++) begin : gen_mul
        logic signed [2*DATA_LEN-1:0] prod_s;
        assign prod_s = $signed(d1[i*DATA_LEN +: DATA_LEN]) * $signed(d2[i*DATA_LEN +: DATA_LEN]);
        assign leaf_s[i*ACC_LEN +: ACC_LEN] = ACC_LEN'(prod_s >>> DATA_DEC);
    end
    assign leaf_s[TAPS*ACC_LEN +: ACC_LEN] = in_first ? ACC_LEN'($signed(bias)) : {ACC_LEN{1'b0}};

    // Stage M register: leaves plus qualified beat flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_flags_r <= 3'b000;
            leaf_r    <= {(LEAVES*ACC_LEN){1'b0}};
        end else if (clr) begin
            m_flags_r <= 3'b000;
        end else begin
            m_flags_r <= '{valid: in_valid, first: in_valid & in_first, last: in_valid & in_last};
            if (in_valid) begin
                leaf_r <= leaf_s;
            end
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : gen_lvl
        localparam int NI = tree_count(LEAVES, k);
        localparam int NO = tree_count(LEAVES, k + 1);
        logic [NI*ACC_LEN-1:0] din_s;
        logic [NO*ACC_LEN-1:0] dout_s;
        beat_flags_t           fin_s;
        beat_flags_t           fout_s;
        if (k == 0) begin : g_src
            assign din_s = leaf_r;
            assign fin_s = m_flags_r;
        end else begin : g_src
            assign din_s = gen_lvl[k-1].dout_s;
            assign fin_s = gen_lvl[k-1].fout_s;
        end
        add_tree_stage #(
            .N (NI),
            .W (ACC_LEN)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .clr       (clr),
            .in_flags  (fin_s),
            .din       (din_s),
            .out_flags (fout_s),
            .dout      (dout_s)
        );
    end

    assign tree_s    = gen_lvl[DEPTH-1].dout_s;
    assign t_flags_s = gen_lvl[DEPTH-1].fout_s;

    // A first beat restarts the sum, any other beat adds onto it.
    always_comb begin
        acc_next_s = acc_r + tree_s;
        if (t_flags_s.first) begin
            acc_next_s = tree_s;
        end else begin
            acc_next_s = acc_r + tree_s;
        end
    end

    // Stage A: accumulator and formatted result strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r     <= {ACC_LEN{1'b0}};
            out_valid <= 1'b0;
            q         <= {DATA_LEN{1'b0}};
        end else if (clr) begin
            acc_r     <= {ACC_LEN{1'b0}};
            out_valid <= 1'b0;
        end else if (t_flags_s.valid) begin
            acc_r     <= acc_next_s;
            out_valid <= t_flags_s.last;
            if (t_flags_s.last) begin
                q <= fmt(acc_next_s, relu_en);
            end
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dot_acc_pipe.sv
// Scoreboard bench for dot_acc_pipe: a saturating and a wrapping instance
// share stimulus; a monitor checks results and their arrival cycle.
module tb_dot_acc_pipe;

    localparam int TAPS = 9;
    localparam int DL   = 16;
    localparam int DW   = TAPS * DL;
    localparam int LAT  = 6;

    typedef struct {
        int          cyc;
        logic [15:0] qs;
        logic [15:0] qw;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clr = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_first = 1'b0;
    logic          in_last = 1'b0;
    logic [DW-1:0] d1 = '0;
    logic [DW-1:0] d2 = '0;
    logic [15:0]   bias = 16'h0000;
    logic          relu_en = 1'b0;
    logic          out_valid, out_valid_w;
    logic [15:0]   q, q_w;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   acc_m = 0;
    exp_t sb[$];

    dot_acc_pipe #(.DATA_LEN(16), .DATA_DEC(8), .TAPS(TAPS), .ACC_LEN(32), .SAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_first(in_first),
        .in_last(in_last), .d1(d1), .d2(d2), .bias(bias), .relu_en(relu_en),
        .out_valid(out_valid), .q(q));

    dot_acc_pipe #(.DATA_LEN(16), .DATA_DEC(8), .TAPS(TAPS), .ACC_LEN(32), .SAT(0)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_first(in_first),
        .in_last(in_last), .d1(d1), .d2(d2), .bias(bias), .relu_en(relu_en),
        .out_valid(out_valid_w), .q(q_w));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [15:0] fmt_m(input int v, input bit sat);
        int r;
        r = (relu_en && v < 0) ? 0 : v;
        if (sat && r > 32767) return 16'h7FFF;
        if (sat && r < -32768) return 16'h8000;
        return r[15:0];
    endfunction

    function automatic logic [DW-1:0] rep(input logic [15:0] v);
        logic [DW-1:0] r;
        for (int i = 0; i < TAPS; i++) r[i*DL +: DL] = v;
        return r;
    endfunction

    function automatic logic [DW-1:0] rnd_vec();
        logic [DW-1:0] r;
        for (int i = 0; i < TAPS; i++) r[i*DL +: DL] = 16'($urandom);
        return r;
    endfunction

    // Drive one cycle of input and advance the reference model.
    task automatic beat(input bit v, input bit f, input bit l, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic [15:0] bi, input bit c);
        longint s;
        @(posedge clk);
        #1;
        in_valid = v; in_first = f; in_last = l; d1 = a; d2 = b; bias = bi; clr = c;
        if (c) begin
            acc_m = 0;
        end else if (v) begin
            s = f ? longint'($signed(bi)) : 64'sd0;
            for (int i = 0; i < TAPS; i++)
                s += (longint'($signed(a[i*DL +: DL])) * longint'($signed(b[i*DL +: DL]))) >>> 8;
            acc_m = f ? int'(s) : acc_m + int'(s);
            if (l) sb.push_back('{cyc + LAT, fmt_m(acc_m, 1'b1), fmt_m(acc_m, 1'b0)});
        end
    endtask

    task automatic idle(input int n);
        repeat (n) beat(1'b0, 1'b0, 1'b0, '0, '0, 16'h0000, 1'b0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 50) begin
            idle(1);
            n++;
        end
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
            sb.delete();
        end
        idle(2);
    endtask

    // Monitor: each expected result must appear exactly on its cycle, nothing else.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                check("out_valid_sat", {15'd0, out_valid}, 16'h0001);
                check("out_valid_wrap", {15'd0, out_valid_w}, 16'h0001);
                check("q_sat", q, e.qs);
                check("q_wrap", q_w, e.qw);
            end else begin
                if (sb.size() > 0 && sb[0].cyc < cyc) begin
                    e = sb.pop_front();
                    total++;
                    bad++;
                    $display("FAIL missed_result: due cycle %0d, now %0d", e.cyc, cyc);
                end
                check("idle_out_valid_sat", {15'd0, out_valid}, 16'h0000);
                check("idle_out_valid_wrap", {15'd0, out_valid_w}, 16'h0000);
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset_out_valid", {15'd0, out_valid}, 16'h0000);
        check("reset_q", q, 16'h0000);
        rst_n = 1'b1;

        // Unit weights, then floor behaviour, then a three-beat group with bias.
        beat(1, 1, 1, rep(16'h0100), rep(16'h0100), 16'h0000, 0);
        idle(7);
        beat(1, 1, 1, rep(16'hFF80), rep(16'h0001), 16'h0000, 0);
        beat(1, 1, 1, rep(16'h0080), rep(16'h0001), 16'h0000, 0);
        idle(3);
        beat(1, 1, 0, rep(16'h0100), rep(16'h0100), 16'h0080, 0);
        beat(1, 0, 0, rep(16'h0100), rep(16'h0100), 16'h0000, 0);
        beat(1, 0, 1, rep(16'h0100), rep(16'h0100), 16'h0000, 0);
        drain();

        // Saturation / wrap / ReLU corners.
        beat(1, 1, 1, rep(16'h7FFF), rep(16'h7FFF), 16'h0000, 0);
        beat(1, 1, 1, rep(16'h8001), rep(16'h7FFF), 16'h0000, 0);
        drain();
        relu_en = 1'b1;
        beat(1, 1, 1, rep(16'h8001), rep(16'h7FFF), 16'h0000, 0);
        beat(1, 1, 1, rnd_vec(), rnd_vec(), 16'($urandom), 0);
        drain();
        relu_en = 1'b0;

        // Twenty back-to-back single-beat groups.
        for (int g = 0; g < 20; g++) beat(1, 1, 1, rnd_vec(), rnd_vec(), 16'($urandom), 0);
        drain();

        // Restart on a second first; a beat with no first adds onto acc.
        beat(1, 1, 0, rnd_vec(), rnd_vec(), 16'($urandom), 0);
        beat(1, 1, 0, rnd_vec(), rnd_vec(), 16'($urandom), 0);
        beat(1, 0, 1, rnd_vec(), rnd_vec(), 16'($urandom), 0);
        beat(1, 0, 1, rnd_vec(), rnd_vec(), 16'($urandom), 0);
        drain();

        // clr mid-group, same-cycle beat dropped, then a beat without first.
        beat(1, 1, 0, rnd_vec(), rnd_vec(), 16'($urandom), 0);
        beat(1, 1, 1, rnd_vec(), rnd_vec(), 16'($urandom), 1);
        beat(1, 0, 1, rep(16'h0100), rep(16'h0100), 16'h0000, 0);
        beat(1, 1, 1, rep(16'h0100), rep(16'h0100), 16'h0000, 0);
        drain();

        // Asynchronous reset mid-group: outputs clear at once, group is lost.
        beat(1, 1, 0, rnd_vec(), rnd_vec(), 16'($urandom), 0);
        beat(1, 0, 0, rnd_vec(), rnd_vec(), 16'($urandom), 0);
        @(posedge clk);
        #3;
        in_valid = 1'b0;
        rst_n = 1'b0;
        acc_m = 0;
        #1;
        check("async_reset_out_valid", {15'd0, out_valid}, 16'h0000);
        check("async_reset_q", q, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        beat(1, 0, 1, rep(16'h0100), rep(16'h0100), 16'h0000, 0);
        drain();

        // Random multi-beat groups with bubbles.
        for (int g = 0; g < 30; g++) begin
            int nb;
            nb = $urandom_range(1, 4);
            for (int b = 0; b < nb; b++) begin
                beat(1, b == 0, b == nb - 1, rnd_vec(), rnd_vec(), 16'($urandom), 0);
                if ($urandom_range(0, 3) == 0) idle(1);
            end
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
